// File: rtl/pwmdemod_pkg.sv
// pwmdemod_pkg: shared state encoding and helpers for the PWM demodulator.
// Rev 1.0
`default_nettype none

package pwmdemod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  // Counters must hold the timeout value plus headroom for saturation.
  function automatic int cnt_width(input int freq, input int tol);
    return $clog2(freq + tol + 2);
  endfunction

  function automatic logic in_window(input int meas, input int nom, input int tol);
    int diff;
    diff = (meas > nom) ? (meas - nom) : (nom - meas);
    return (diff <= tol);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwmdemod_edge.sv
// pwmdemod_edge: 2-flop synchronizer, optional 3-sample majority filter
// (PWMDEMOD_GLITCH_FILTER_EN), registered rise/fall strobes. Rev 1.0
`default_nettype none

module pwmdemod_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic s1, s2, cur, prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

`ifdef PWMDEMOD_GLITCH_FILTER_EN
  logic f1, f2;

  // Any single-sample excursion is outvoted by its two neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      f1  <= 1'b0;
      f2  <= 1'b0;
      cur <= 1'b0;
    end else begin
      f1  <= s2;
      f2  <= f1;
      cur <= (s2 & f1) | (s2 & f2) | (f1 & f2);
    end
  end
`else
  assign cur = s2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      prev <= cur;
      rise <= cur & ~prev;
      fall <= ~cur & prev;
    end
  end

  // prev is the level aligned with the strobes.
  assign sync_out = prev;

endmodule

`default_nettype wire

// File: rtl/pwmdemod.sv
// pwmdemod: recovers a 1-bit level from a PWM carrier by checking period and
// high time. Optional input filter via PWMDEMOD_GLITCH_FILTER_EN. Rev 1.0
`default_nettype none

module pwmdemod
  import pwmdemod_pkg::*;
#(
  parameter int DIVIDER_FREQ  = 10,
  parameter int DIVIDER_DTY   = 3,
  parameter int TOLERANCE     = 1,
  parameter int VALID_PERIODS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic err
);

  localparam int CNT_W  = cnt_width(DIVIDER_FREQ, TOLERANCE);
  localparam int GOOD_W = $clog2(VALID_PERIODS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  TIMEOUT   = CNT_W'(DIVIDER_FREQ + TOLERANCE + 1);
  localparam logic [CNT_W-1:0]  STUCK     = CNT_W'(DIVIDER_DTY + TOLERANCE + 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(VALID_PERIODS - 1);

  logic              level, rise, fall;
  logic [CNT_W-1:0]  per_cnt, hi_cnt, hi_meas;
  logic [GOOD_W-1:0] good_cnt;
  logic              period_ok;
  state_t            state;

  pwmdemod_edge u_edge (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .sync_out(level),
    .rise    (rise),
    .fall    (fall)
  );

  assign period_ok = in_window(int'(per_cnt), DIVIDER_FREQ, TOLERANCE) &&
                     in_window(int'(hi_meas), DIVIDER_DTY, TOLERANCE);

  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt  <= '0;
      hi_cnt   <= '0;
      hi_meas  <= '0;
      good_cnt <= '0;
      state    <= IDLE;
      dout     <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;

      if (rise) begin
        per_cnt <= CNT_W'(1);
        hi_cnt  <= CNT_W'(1);
      end else begin
        if (per_cnt != CNT_MAX) per_cnt <= per_cnt + 1'b1;
        if (level && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + 1'b1;
      end
      if (fall) hi_meas <= hi_cnt;

      case (state)
        IDLE: begin
          if (rise) begin
            state    <= ACQ;
            good_cnt <= '0;
          end
        end
        ACQ, LOCK: begin
          // On a rise hi_cnt still holds last period's value, so the
          // stuck-high test only applies between rises.
          if (!rise && level && hi_cnt == STUCK) begin
            err   <= 1'b1;
            dout  <= 1'b0;
            state <= IDLE;
          end else if (rise) begin
            if (!period_ok) begin
              err      <= 1'b1;
              dout     <= 1'b0;
              state    <= ACQ;
              good_cnt <= '0;
            end else if (state == ACQ) begin
              if (good_cnt == GOOD_LAST) begin
                state    <= LOCK;
                dout     <= 1'b1;
                good_cnt <= '0;
              end else begin
                good_cnt <= good_cnt + 1'b1;
              end
            end
          end else if (per_cnt == TIMEOUT) begin
            dout  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          dout  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pwmdemod.sv
// tb_pwmdemod: directed carrier patterns; expected dout/err events are queued
// up front and matched by an independent monitor. Rev 1.0
`default_nettype none

module tb_pwmdemod;

`ifdef PWMDEMOD_GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif
  // LAT: pin change to the clock edge where the FSM acts on it.
  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_ERR  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic dout, err;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic prev_dout = 1'b0;

  typedef struct {
    int kind;
    int t;
  } ev_t;
  ev_t exp_q[$];

  pwmdemod #(
    .DIVIDER_FREQ (10),
    .DIVIDER_DTY  (3),
    .TOLERANCE    (1),
    .VALID_PERIODS(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .dout(dout),
    .err (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int kind, input int t);
    ev_t e;
    e.kind = kind;
    e.t    = t;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event got kind=%0d cycle=%0d required none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.t != cyc) begin
        errors++;
        $display("FAIL event got kind=%0d cycle=%0d required kind=%0d cycle=%0d",
                 kind, cyc, e.kind, e.t);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (dout !== prev_dout) begin
        check_ev((dout === 1'b1) ? K_RISE : K_FALL);
        prev_dout = dout;
      end
      if (err !== 1'b0) check_ev(K_ERR);
    end
  end

  // All drive tasks start and end #1 after a rising edge.
  task automatic pwm_period(input int hi, input int per);
    din = 1'b1;
    repeat (hi) @(posedge clk);
    #1 din = 1'b0;
    repeat (per - hi) @(posedge clk);
    #1;
  endtask

  task automatic glitch_period();
    din = 1'b1;
    repeat (2) @(posedge clk);
    #1 din = 1'b0;
    @(posedge clk);
    #1 din = 1'b1;
    @(posedge clk);
    #1 din = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    din = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int per_l[9] = '{10, 10, 10, 10, 11, 12, 10, 10, 10};
  int t0, t1, t2, ts;

  initial begin
    // Reset with carrier present: outputs must stay low.
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      din = (i < 3);
      @(posedge clk);
      #1;
      checks++;
      if (dout !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs dout=%b err=%b required 0 0", dout, err);
      end
    end
    din = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;
    idle(20);

    // Clean carrier, jitter 11 (tolerated) then 12 (rejected), relock, stop low.
    t0 = cyc;
    expect_ev(K_RISE, t0 + 20 + LAT);
    expect_ev(K_FALL, t0 + 63 + LAT);
    expect_ev(K_ERR,  t0 + 63 + LAT);
    expect_ev(K_RISE, t0 + 83 + LAT);
    expect_ev(K_FALL, t0 + 93 + LAT + 12);
    for (int i = 0; i < 9; i++) pwm_period(3, per_l[i]);
    pwm_period(3, 10);
    idle(30);

    // Foreign 20/10 carrier: each high phase trips the stuck-high check.
    t1 = cyc;
    for (int k = 0; k < 10; k++) expect_ev(K_ERR, t1 + 20 * k + LAT + 5);
    for (int k = 0; k < 10; k++) pwm_period(10, 20);
    idle(30);

    // Lock, optional glitched period, then input held high for 10 clocks.
    t2 = cyc;
`ifdef PWMDEMOD_GLITCH_FILTER_EN
    ts = 50;
`else
    ts = 30;
`endif
    expect_ev(K_RISE, t2 + 20 + LAT);
    expect_ev(K_FALL, t2 + ts + LAT + 5);
    expect_ev(K_ERR,  t2 + ts + LAT + 5);
    for (int i = 0; i < 3; i++) pwm_period(3, 10);
`ifdef PWMDEMOD_GLITCH_FILTER_EN
    glitch_period();
    pwm_period(3, 10);
`endif
    pwm_period(10, 40);
    idle(20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got %0d outstanding required 0 (next kind=%0d cycle=%0d)",
               exp_q.size(), exp_q[0].kind, exp_q[0].t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
